// File: rtl/mux_pkg.sv
//============================================================================
// Module : mux_pkg
// Brief  : Shared constants and index-width helpers for the mux family.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package mux_pkg;

    localparam int DATA_W = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single channel still needs a one-bit index port.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage : mux_pkg

`default_nettype wire

// File: rtl/arb_mux_rr_pick.sv
//============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first request at or after ptr.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module rr_pick
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] gidx,
    output logic            any_req
);

    int w_hi;
    int w_lo;
    int w_sel;

    // Lowest requester at/above ptr wins; otherwise lowest one below it (wrap).
    always_comb begin
        w_hi = -1;
        w_lo = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i >= int'(ptr)) begin
                    w_hi = i;
                end else begin
                    w_lo = i;
                end
            end
        end
        w_sel   = (w_hi >= 0) ? w_hi : w_lo;
        any_req = (w_sel >= 0);
        gidx    = any_req ? SELW'(w_sel) : '0;
        grant   = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = (w_sel == i);
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/arb_mux.sv
//============================================================================
// Module : arb_mux
// Brief  : N-channel arbitrating mux with valid/ready and registered output.
// Config : ARB_MUX_FIXED_PRIO_EN selects fixed lowest-index priority.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module arb_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH = DATA_W,
    parameter  int N     = 4,
    localparam int SELW  = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SELW-1:0]     r_out_sel;
    logic                w_load;
    logic [N-1:0]        w_req;
    logic [N-1:0]        w_grant;
    logic [SELW-1:0]     w_gidx;
    logic                w_any;
    logic [SELW-1:0]     w_ptr;
    logic [WIDTH-1:0]    w_win_data;

    assign w_load = !r_out_valid || out_ready;
    // Masking requests keeps every grant (and hence in_ready) low in reset and stall.
    assign w_req  = (reset || !w_load) ? '0 : in_valid;

    rr_pick #(.N(N)) u_pick (
        .req     (w_req),
        .ptr     (w_ptr),
        .grant   (w_grant),
        .gidx    (w_gidx),
        .any_req (w_any)
    );

    assign in_ready = w_grant;

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_win_data = w_win_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_ptr_next;

    // Explicit wrap so non-power-of-two N never points past the last channel.
    assign w_ptr_next = (w_gidx == SELW'(N - 1)) ? '0 : (w_gidx + SELW'(1));
    assign w_ptr      = r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_win_data;
                r_out_sel  <= w_gidx;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule : arb_mux

`default_nettype wire
